// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg -- shared definitions for the fetch sequencer.
//   Opcode field position and opcode values of the instruction set,
//   jump-target field width, and the sequencer state encoding.
package fetch_seq_pkg;

    localparam int unsigned IwW    = 16;  // instruction word width
    localparam int unsigned PcW    = 6;   // instruction address width
    localparam int unsigned OpMsb  = 15;  // opcode field [15:11]
    localparam int unsigned OpLsb  = 11;
    localparam int unsigned TgtMsb = 5;   // jump target field [5:0]

    typedef enum logic [4:0] {
        OpCopy       = 5'd1,
        OpJmp        = 5'd2,
        OpJnz        = 5'd3,
        OpStore      = 5'd4,
        OpCheck      = 5'd5,
        OpComp       = 5'd6,
        OpInc        = 5'd7,
        OpPossibleLo = 5'd8,
        OpPossibleHi = 5'd9,
        OpCheck4     = 5'd10
    } opcode_e;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StIssue = 3'd2,
        StWait  = 3'd3,
        StHalt  = 3'd4
    } state_e;

    function automatic logic [OpMsb-OpLsb:0] get_op(input logic [IwW-1:0] word);
        return word[OpMsb:OpLsb];
    endfunction

    function automatic logic [PcW-1:0] get_tgt(input logic [IwW-1:0] word);
        return word[TgtMsb:0];
    endfunction

endpackage

// File: rtl/fetch_seq.sv
// fetch_seq -- instruction fetch/issue sequencer with external combinational imem.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : begin execution at address 0 (honoured in IDLE and HALT only)
//   pc, op_in    : address to instruction memory and the word it returns
//   ir, ir_valid : issued instruction and its one-cycle issue pulse
//   exec_done    : execute stage finished the issued instruction; flag_in sampled with it
//   halted       : high while halted after a STORE completes
// Optional feature (macro FETCH_SEQ_ICOUNT_EN): output icount, a saturating
// count of issue pulses, cleared by start and reset.
module fetch_seq
    import fetch_seq_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic [PcW-1:0] pc,
    input  logic [IwW-1:0] op_in,
    output logic [IwW-1:0] ir,
    output logic           ir_valid,
    input  logic           exec_done,
    input  logic           flag_in,
    output logic           halted
`ifdef FETCH_SEQ_ICOUNT_EN
    ,
    output logic [15:0]    icount
`endif
);

    state_e         state_q, state_d;
    logic [PcW-1:0] pc_q, pc_d;
    logic [IwW-1:0] ir_q, ir_d;
    logic           ir_valid_q, ir_valid_d;
    logic           flag_q, flag_d;
    logic           halted_q, halted_d;
`ifdef FETCH_SEQ_ICOUNT_EN
    logic [15:0]    icount_q, icount_d;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        flag_d     = flag_q;
        ir_valid_d = 1'b0;
`ifdef FETCH_SEQ_ICOUNT_EN
        icount_d   = icount_q;
`endif
        case (state_q)
            StIdle, StHalt: begin
                if (start) begin
                    pc_d    = '0;
                    flag_d  = 1'b0;
                    state_d = StFetch;
`ifdef FETCH_SEQ_ICOUNT_EN
                    icount_d = '0;
`endif
                end
            end
            StFetch: begin
                // Jumps resolve here without issuing; any other word (even an
                // undefined or X-containing one) falls through to issue.
                if (get_op(op_in) == OpJmp) begin
                    pc_d = get_tgt(op_in);
                end else if (get_op(op_in) == OpJnz) begin
                    pc_d = flag_q ? get_tgt(op_in) : pc_q + 6'd1;
                end else begin
                    ir_d       = op_in;
                    ir_valid_d = 1'b1;
                    state_d    = StIssue;
`ifdef FETCH_SEQ_ICOUNT_EN
                    if (icount_q != 16'hFFFF) begin
                        icount_d = icount_q + 16'd1;
                    end
`endif
                end
            end
            StIssue, StWait: begin
                if (exec_done) begin
                    flag_d  = flag_in;
                    pc_d    = pc_q + 6'd1;
                    state_d = (get_op(ir_q) == OpStore) ? StHalt : StFetch;
                end else begin
                    state_d = StWait;
                end
            end
            default: state_d = StIdle;
        endcase
        halted_d = (state_d == StHalt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            flag_q     <= 1'b0;
            halted_q   <= 1'b0;
`ifdef FETCH_SEQ_ICOUNT_EN
            icount_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            flag_q     <= flag_d;
            halted_q   <= halted_d;
`ifdef FETCH_SEQ_ICOUNT_EN
            icount_q   <= icount_d;
`endif
        end
    end

    assign pc       = pc_q;
    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;
    assign halted   = halted_q;
`ifdef FETCH_SEQ_ICOUNT_EN
    assign icount   = icount_q;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq -- self-checking bench for fetch_seq with a behavioural model
// and a bench-owned instruction memory.
module tb_fetch_seq;
    import fetch_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        exec_done = 1'b0;
    logic        flag_in = 1'b0;
    logic [5:0]  pc;
    logic [15:0] op_in;
    logic [15:0] ir;
    logic        ir_valid;
    logic        halted;
`ifdef FETCH_SEQ_ICOUNT_EN
    logic [15:0] icount;
`endif

    logic [15:0] mem [64];
    assign op_in = mem[pc];

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    fetch_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pc        (pc),
        .op_in     (op_in),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .exec_done (exec_done),
        .flag_in   (flag_in),
        .halted    (halted)
`ifdef FETCH_SEQ_ICOUNT_EN
        ,
        .icount    (icount)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a program is either not running (idle/halted), fetching, or has
    // one instruction outstanding until execute reports done.
    logic [5:0]  m_pc;
    logic [15:0] m_ir;
    logic        m_valid, m_halt, m_flag, m_run, m_out;
    int          m_cnt;

    always @(posedge clk or negedge rst_n) begin : model
        logic [5:0]  p;
        logic [15:0] w, r;
        logic        v, h, f, run, out;
        int          c;
        if (!rst_n) begin
            m_pc <= '0; m_ir <= '0; m_valid <= 1'b0; m_halt <= 1'b0;
            m_flag <= 1'b0; m_run <= 1'b0; m_out <= 1'b0; m_cnt <= 0;
        end else begin
            p = m_pc; r = m_ir; v = 1'b0; h = m_halt; f = m_flag;
            run = m_run; out = m_out; c = m_cnt;
            if (!run) begin
                if (start) begin
                    p = '0; f = 1'b0; run = 1'b1; h = 1'b0; c = 0;
                end
            end else if (!out) begin
                w = mem[p];
                if (w[15:11] == OpJmp) p = w[5:0];
                else if (w[15:11] == OpJnz) p = f ? w[5:0] : p + 6'd1;
                else begin
                    r = w; out = 1'b1; v = 1'b1;
                    if (c < 65535) c++;
                end
            end else if (exec_done) begin
                f = flag_in; p = p + 6'd1; out = 1'b0;
                if (r[15:11] == OpStore) begin
                    run = 1'b0; h = 1'b1;
                end
            end
            m_pc <= p; m_ir <= r; m_valid <= v; m_halt <= h;
            m_flag <= f; m_run <= run; m_out <= out; m_cnt <= c;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_pc", {10'd0, pc}, {10'd0, m_pc});
            chk("model_ir", ir, m_ir);
            chk("model_ir_valid", {15'd0, ir_valid}, {15'd0, m_valid});
            chk("model_halted", {15'd0, halted}, {15'd0, m_halt});
`ifdef FETCH_SEQ_ICOUNT_EN
            chk("model_icount", icount, m_cnt[15:0]);
`endif
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_issue();
        int n = 0;
        while (!ir_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("issue_timeout", {15'd0, ir_valid}, 16'd1);
    endtask

    // Wait for an issue, let it sit for dly cycles, then report done.
    task automatic exec(input int dly, input logic flg);
        wait_issue();
        repeat (dly) @(negedge clk);
        exec_done = 1'b1;
        flag_in   = flg;
        @(negedge clk);
        exec_done = 1'b0;
        flag_in   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = {OpInc, 11'd0};
        mem[0]  = 16'h0923;                  // COPY
        mem[1]  = {OpCheck, 11'd0};
        mem[2]  = {OpJnz, 5'd0, 6'd13};
        mem[13] = {OpCheck, 11'd0};
        mem[14] = {OpJnz, 5'd0, 6'd13};
        mem[16] = {OpJmp, 5'd0, 6'd0};
        mem[41] = {OpStore, 11'd0};
        mem[4]  = {OpJmp, 5'd0, 6'd63};
        mem[63] = {OpComp, 11'd0};

        #1 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_pc", {10'd0, pc}, 16'd0);
        chk("reset_ir", ir, 16'd0);
        chk("reset_valid", {15'd0, ir_valid}, 16'd0);
        chk("reset_halted", {15'd0, halted}, 16'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_issue_before_start", {15'd0, ir_valid}, 16'd0);

        // COPY at 0 issues two cycles after start.
        pulse_start();
        chk("fetch_no_valid", {15'd0, ir_valid}, 16'd0);
        @(negedge clk);
        chk("copy_valid", {15'd0, ir_valid}, 16'd1);
        chk("copy_ir", ir, 16'h0923);
        @(negedge clk);
        chk("valid_one_cycle", {15'd0, ir_valid}, 16'd0);
        start = 1'b1;                        // ignored while waiting
        @(negedge clk);
        start = 1'b0;
        chk("wait_pc_stable", {10'd0, pc}, 16'd0);
        chk("wait_ir_stable", ir, 16'h0923);
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        chk("copy_done_pc", {10'd0, pc}, 16'd1);

        // CHECK done in its issue cycle, flag=1, then JNZ 13 taken.
        exec(0, 1'b1);
        chk("same_cycle_done_pc", {10'd0, pc}, 16'd2);
        @(negedge clk);
        chk("jnz_taken_pc", {10'd0, pc}, 16'd13);
        chk("jnz_no_valid", {15'd0, ir_valid}, 16'd0);

        // CHECK with flag=0, then JNZ untaken.
        exec(1, 1'b0);
        chk("check2_done_pc", {10'd0, pc}, 16'd14);
        @(negedge clk);
        chk("jnz_untaken_pc", {10'd0, pc}, 16'd15);

        // INC at 15, then JMP 0 at 16.
        exec(0, 1'b0);
        chk("inc_done_pc", {10'd0, pc}, 16'd16);
        @(negedge clk);
        chk("jmp_pc", {10'd0, pc}, 16'd0);
        chk("jmp_no_valid", {15'd0, ir_valid}, 16'd0);
        mem[0] = {OpJmp, 5'd0, 6'd41};

        // STORE at 41 halts with pc=42.
        exec(1, 1'b0);
        chk("store_halted", {15'd0, halted}, 16'd1);
        chk("store_pc", {10'd0, pc}, 16'd42);
        repeat (3) begin
            exec_done = 1'b1;                // ignored in halt
            @(negedge clk);
        end
        exec_done = 1'b0;
        chk("halt_pc_stable", {10'd0, pc}, 16'd42);
        chk("halt_hold", {15'd0, halted}, 16'd1);
        mem[0] = 16'h0923;
        pulse_start();
        chk("restart_pc", {10'd0, pc}, 16'd0);
        chk("restart_halted", {15'd0, halted}, 16'd0);

        // Reset mid-wait.
        wait_issue();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_pc", {10'd0, pc}, 16'd0);
        chk("midrst_ir", ir, 16'd0);
        chk("midrst_valid", {15'd0, ir_valid}, 16'd0);
        chk("midrst_halted", {15'd0, halted}, 16'd0);
`ifdef FETCH_SEQ_ICOUNT_EN
        chk("midrst_icount", icount, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("no_issue_after_reset", {15'd0, ir_valid}, 16'd0);

        // Three issues, then pc wrap 63 -> 0.
        pulse_start();
        exec(0, 1'b0);
        exec(0, 1'b0);
        exec(2, 1'b1);
        chk("third_done_pc", {10'd0, pc}, 16'd4);
`ifdef FETCH_SEQ_ICOUNT_EN
        chk("icount_three", icount, 16'd3);
`endif
        exec(0, 1'b0);
        chk("pc_wrap", {10'd0, pc}, 16'd0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  single-cycle request to begin program execution at address 0.
REQ-005 pc  output  6  instruction address driven to the combinational instruction memory.
REQ-006 op_in  input  16  instruction word returned by instruction memory for pc, valid in the same cycle.
REQ-007 ir  output  16  registered instruction issued to the execute stage.
REQ-008 ir_valid  output  1  one-cycle pulse marking ir as a new issue.
REQ-009 exec_done  input  1  execute stage has completed the issued instruction.
REQ-010 flag_in  input  1  condition result from execute (CHECK/COMP/POSSIBLE_*/CHECK_4), sampled with exec_done.
REQ-011 halted  output  1  high while in HALT.

Function
REQ-012 The block SHALL implement states IDLE, FETCH, ISSUE, WAIT and HALT.
REQ-013 In IDLE, start=1 SHALL set pc=0 and flag_r=0, then enter FETCH; all other inputs are ignored.
REQ-014 In FETCH with op_in[15:11]=JMP, the block SHALL load pc=op_in[5:0], remain in FETCH, and not pulse ir_valid.
REQ-015 In FETCH with op_in[15:11]=JNZ, the block SHALL load pc=op_in[5:0] if flag_r=1, else pc+1, and remain in FETCH with no issue.
REQ-016 In FETCH with any other opcode, including X-containing or undefined words, the block SHALL latch ir=op_in and enter ISSUE.
REQ-017 In ISSUE, the block SHALL hold ir_valid=1 for exactly one cycle, then enter WAIT unless exec_done=1 in that same cycle.
REQ-018 When exec_done=1 in ISSUE or WAIT, the block SHALL latch flag_r=flag_in and set pc=pc+1.
REQ-019 After the exec_done of REQ-018, the block SHALL go to HALT if ir[15:11]=STORE, else to FETCH.
REQ-020 pc arithmetic SHALL be modulo 64, so 63+1=0.
REQ-021 ir and pc SHALL remain stable in WAIT and HALT.
REQ-022 exec_done received in FETCH, IDLE or HALT SHALL be ignored.
REQ-023 In HALT, start=1 SHALL restart exactly as in REQ-013.
REQ-024 start asserted in FETCH, ISSUE or WAIT SHALL be ignored.
REQ-025 Latency: a non-jump instruction SHALL issue 2 cycles after its pc is presented; each taken or untaken jump SHALL cost 1 cycle.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state=IDLE, pc=0, ir=0, ir_valid=0, flag_r=0 and halted=0, including mid-WAIT.
REQ-027 After reset release, no ir_valid pulse SHALL occur before start is asserted.

Configuration
REQ-028 With macro FETCH_SEQ_ICOUNT_EN defined, the block SHALL add output icount[15:0] counting ir_valid pulses.
REQ-029 icount SHALL saturate at 16'hFFFF, clear on start and reset, and hold in HALT.
REQ-030 Without FETCH_SEQ_ICOUNT_EN, the icount port and its logic SHALL be absent, with no other behavioural change.

Structure
REQ-031 Opcode constants (COPY, JMP, JNZ, STORE, CHECK, COMP, INC, ...) and the opcode field position [15:11] SHALL come from the shared def.h definitions; jump target field [5:0] SHALL be a shared constant.
REQ-032 State encoding SHALL be a local parameter set.
REQ-033 No sub-module is required; the instruction memory SHALL remain external.

Verification
REQ-034 Reset, then start; op at 0 = COPY: ir=COPY word, ir_valid pulse 2 cycles after start; exec_done 3 cycles later -> pc=1.
REQ-035 Word at pc=16 = JMP 0: pc=0 next cycle, no ir_valid pulse.
REQ-036 CHECK issued, exec_done with flag_in=1, then JNZ 13 -> pc=13; repeat with flag_in=0 -> pc=next address.
REQ-037 exec_done in the same cycle as ir_valid: WAIT skipped, FETCH on next cycle, pc incremented once.
REQ-038 STORE at 41 completes -> halted=1 and pc=42 stable; start -> pc=0, halted=0.
REQ-039 rst_n pulled low mid-WAIT -> all outputs at reset values immediately; with FETCH_SEQ_ICOUNT_EN, icount=0 and counts 3 after three issues.
